// File: rtl/duc_burst_arbiter.sv
// rtl/duc_burst_arbiter.sv - round-robin burst arbiter feeding the DUC input stage
module duc_burst_arbiter #(
  parameter  int WIDTH     = 32,
  parameter  int NUM_CH    = 4,
  parameter  int BURST_LEN = 16,
  localparam int CW        = $clog2(NUM_CH)
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
  input  logic [NUM_CH-1:0]       i_req_valid,
  input  logic [NUM_CH*WIDTH-1:0] i_req_data,
  output logic [NUM_CH-1:0]       o_req_ready,
  output logic [WIDTH-1:0]        o_out_data,
  output logic [CW-1:0]           o_out_chan,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [NUM_CH-1:0]       o_grant,
  output logic                    o_burst_done
);

  localparam int CNTW = $clog2(BURST_LEN + 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [CW-1:0]     last_q, last_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [CW-1:0]     out_chan_q, out_chan_d;
  logic              done_q, done_d;

  logic              load_ok;
  logic              up_beat;
  logic              gnt_valid;
  logic [WIDTH-1:0]  sel_data;
  logic [CW-1:0]     sel_chan;
  logic              found;
  logic [CW-1:0]     pick;
  logic [CW-1:0]     cand;

  // Handshake qualification and mux of the granted channel's sample
  always_comb begin
    load_ok     = !out_valid_q || i_out_ready;
    o_req_ready = ((state_q == ST_BURST) && load_ok) ? grant_q : '0;
    up_beat     = |(i_req_valid & o_req_ready);
    gnt_valid   = |(i_req_valid & grant_q);
    sel_data    = '0;
    sel_chan    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_q[k]) begin
        sel_data = i_req_data[k*WIDTH +: WIDTH];
        sel_chan = CW'(k);
      end
    end
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CW'((int'(last_q) + i) % NUM_CH);
      if (!found && i_req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Grant FSM: issue a grant from IDLE, count beats and end the burst on limit or drain
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_enable && found) begin
          state_d       = ST_BURST;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          last_d        = pick;
          cnt_d         = '0;
        end
      end
      ST_BURST: begin
        if ((up_beat && (cnt_q == CNTW'(BURST_LEN - 1))) || (!gnt_valid && load_ok)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          done_d  = 1'b1;
        end else if (up_beat) begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Output register: load on an upstream beat, otherwise empty on a downstream beat
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (up_beat) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_chan_d  = sel_chan;
    end else if (out_valid_q && i_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and datapath registers; reset drops any held beat
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= CW'(NUM_CH - 1);
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      done_q      <= done_d;
    end
  end

  assign o_out_valid  = out_valid_q;
  assign o_out_data   = out_data_q;
  assign o_out_chan   = out_chan_q;
  assign o_grant      = grant_q;
  assign o_burst_done = done_q;

endmodule

// File: tb/tb_duc_burst_arbiter.sv
// tb/tb_duc_burst_arbiter.sv - scoreboard bench for duc_burst_arbiter
module tb_duc_burst_arbiter;

  logic         i_clock = 1'b0;
  logic         i_reset_n;
  logic         i_enable;
  logic [3:0]   i_req_valid;
  logic [127:0] i_req_data;
  logic [3:0]   o_req_ready;
  logic [31:0]  o_out_data;
  logic [1:0]   o_out_chan;
  logic         o_out_valid;
  logic         i_out_ready;
  logic [3:0]   o_grant;
  logic         o_burst_done;

  duc_burst_arbiter #(.WIDTH(32), .NUM_CH(4), .BURST_LEN(4)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .o_req_ready(o_req_ready),
    .o_out_data(o_out_data), .o_out_chan(o_out_chan), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_grant(o_grant), .o_burst_done(o_burst_done)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [1:0]  chan;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          len_log[$];
  int          grant_log[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          sent[4];
  int          lim[4];
  logic [31:0] base[4];
  logic [3:0]  en;
  logic [3:0]  acc;
  int          beats;
  int          done_cnt;
  int          rx_cnt;
  logic        stall_prev;
  logic [31:0] hold_data;
  logic [3:0]  prev_grant;
  int          ex[$];

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_q(string tag, int act[$], int exp[$]);
    chk({tag, "_count"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      chk($sformatf("%s_%0d", tag, i), act[i], exp[i]);
  endtask

  function automatic int oh2i(logic [3:0] g);
    int r = -1;
    for (int k = 0; k < 4; k++) if (g[k]) r = k;
    return r;
  endfunction

  task automatic push_seq(int ch, logic [31:0] b, int first, int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.chan = 2'(ch);
      e.data = b + 32'(first + i);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_sample();
    @(negedge i_clock);
    #2;
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    #1;
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_data", o_out_data, 0);
    chk("rst_out_chan", o_out_chan, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_burst_done", o_burst_done, 0);
    chk("rst_req_ready", o_req_ready, 0);
    exp_q.delete();
    len_log.delete();
    grant_log.delete();
    for (int k = 0; k < 4; k++) begin
      sent[k] = 0;
      lim[k]  = 0;
      base[k] = '0;
    end
    en = '0; acc = '0; beats = 0; done_cnt = 0; rx_cnt = 0;
    stall_prev = 1'b0; prev_grant = '0;
    i_enable = 1'b1;
    i_out_ready = 1'b1;
    repeat (2) @(posedge i_clock);
    #1;
    i_reset_n = 1'b1;
  endtask

  task automatic drain(string tag, int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge i_clock);
      c++;
    end
    repeat (4) @(negedge i_clock);
    #2;
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Source drivers, acceptance tracking and output scoreboard
  always @(negedge i_clock) begin
    exp_t e;
    for (int k = 0; k < 4; k++) if (acc[k]) sent[k]++;
    beats += $countones(acc);
    for (int k = 0; k < 4; k++) begin
      i_req_valid[k] = en[k] && (sent[k] < lim[k]);
      i_req_data[k*32 +: 32] = base[k] + 32'(sent[k]);
    end
    acc = i_req_valid & o_req_ready;
    if (i_reset_n) begin
      if (o_out_valid && i_out_ready) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", o_out_data, e.data);
          chk("out_chan", o_out_chan, e.chan);
        end
      end
      if (o_out_valid && !i_out_ready) chk("stall_ready", o_req_ready, 0);
      if (stall_prev && o_out_valid) chk("stall_hold", o_out_data, hold_data);
      stall_prev = o_out_valid && !i_out_ready;
      hold_data  = o_out_data;
      if (o_burst_done) begin
        done_cnt++;
        len_log.push_back(beats);
        beats = 0;
        chk("done_grant", o_grant, 0);
        chk("done_ready", o_req_ready, 0);
      end
      if (o_grant != 4'b0 && o_grant != prev_grant) grant_log.push_back(oh2i(o_grant));
      prev_grant = o_grant;
    end
  end

  initial begin
    i_reset_n = 1'b1; i_enable = 1'b1; i_out_ready = 1'b1;
    i_req_valid = '0; i_req_data = '0; en = '0; acc = '0;
    for (int k = 0; k < 4; k++) begin sent[k] = 0; lim[k] = 0; base[k] = '0; end
    #3;

    // single channel 2, ten samples, latency and 4/4/2 bursts
    do_reset();
    base[2] = 32'h100; lim[2] = 10; en[2] = 1'b1;
    push_seq(2, 32'h100, 0, 10);
    wait_sample();
    chk("lat_t0_grant", o_grant, 0);
    wait_sample();
    chk("lat_t1_grant", o_grant, 4'b0100);
    chk("lat_t1_ready", o_req_ready, 4'b0100);
    chk("lat_t1_valid", o_out_valid, 0);
    wait_sample();
    chk("lat_t2_valid", o_out_valid, 1);
    drain("single", 100);
    chk("single_done_cnt", done_cnt, 3);
    ex = {4, 4, 2}; chk_q("single_len", len_log, ex);
    ex = {2, 2, 2}; chk_q("single_grant", grant_log, ex);

    // all channels continuous: round-robin order and per-channel data
    do_reset();
    for (int k = 0; k < 4; k++) begin
      base[k] = 32'h1000 * (k + 1); lim[k] = 8; en[k] = 1'b1;
    end
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) push_seq(k, 32'h1000 * (k + 1), r * 4, 4);
    drain("rr", 200);
    ex = {0, 1, 2, 3, 0, 1, 2, 3}; chk_q("rr_grant", grant_log, ex);
    ex = {4, 4, 4, 4, 4, 4, 4, 4}; chk_q("rr_len", len_log, ex);

    // backpressure pattern 1,0,0,1 on channel 1
    do_reset();
    base[1] = 32'h200; lim[1] = 6; en[1] = 1'b1;
    push_seq(1, 32'h200, 0, 6);
    for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin
      @(posedge i_clock);
      #1;
      i_out_ready = (c % 4 == 0) || (c % 4 == 3);
    end
    i_out_ready = 1'b1;
    drain("bp", 50);
    chk("bp_rx_cnt", rx_cnt, 6);
    ex = {4, 2}; chk_q("bp_len", len_log, ex);

    // early drain on channel 1 hands over to channel 2
    do_reset();
    base[1] = 32'h210; lim[1] = 3; en[1] = 1'b1;
    base[2] = 32'h220; lim[2] = 4; en[2] = 1'b1;
    push_seq(1, 32'h210, 0, 3);
    push_seq(2, 32'h220, 0, 4);
    drain("early", 100);
    ex = {1, 2}; chk_q("early_grant", grant_log, ex);
    ex = {3, 4}; chk_q("early_len", len_log, ex);

    // enable gating: no grant while low, mid-burst drop completes the burst
    do_reset();
    i_enable = 1'b0;
    base[0] = 32'h50; lim[0] = 8; en[0] = 1'b1;
    push_seq(0, 32'h50, 0, 8);
    repeat (5) begin
      wait_sample();
      chk("en_off_grant", o_grant, 0);
    end
    @(posedge i_clock);
    #1;
    i_enable = 1'b1;
    for (int c = 0; c < 10 && o_grant == 4'b0; c++) wait_sample();
    chk("en_on_grant", o_grant, 4'b0001);
    @(posedge i_clock);
    #1;
    i_enable = 1'b0;
    repeat (10) wait_sample();
    chk("en_mid_rx", rx_cnt, 4);
    chk("en_mid_grant", o_grant, 0);
    ex = {4}; chk_q("en_mid_len", len_log, ex);
    @(posedge i_clock);
    #1;
    i_enable = 1'b1;
    drain("en", 100);
    ex = {4, 4}; chk_q("en_len", len_log, ex);

    // reset mid-burst with a stalled beat, then channel 0 wins first
    do_reset();
    i_out_ready = 1'b0;
    base[1] = 32'h200; lim[1] = 6; en[1] = 1'b1;
    for (int c = 0; c < 10 && !o_out_valid; c++) wait_sample();
    chk("mid_rst_stalled", o_out_valid, 1);
    do_reset();
    base[0] = 32'h10;  lim[0] = 2; en[0] = 1'b1;
    base[3] = 32'h300; lim[3] = 3; en[3] = 1'b1;
    push_seq(0, 32'h10, 0, 2);
    push_seq(3, 32'h300, 0, 3);
    drain("post_rst", 100);
    ex = {0, 3}; chk_q("post_rst_grant", grant_log, ex);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
